// File: rtl/schedw_pkg.sv
// Shared constants for the schedw phase sequencer: state codes, bus-phase codes, wait width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package schedw_pkg;

  localparam int WCNT_W = 4;

  localparam logic [2:0] S_HALT = 3'd0;
  localparam logic [2:0] S_WF   = 3'd1;
  localparam logic [2:0] S_F    = 3'd2;
  localparam logic [2:0] S_E    = 3'd3;
  localparam logic [2:0] S_WM   = 3'd4;
  localparam logic [2:0] S_M    = 3'd5;
  localparam logic [2:0] S_W    = 3'd6;

  localparam logic [1:0] BP_F = 2'd0;
  localparam logic [1:0] BP_E = 2'd1;
  localparam logic [1:0] BP_M = 2'd2;
  localparam logic [1:0] BP_W = 2'd3;

endpackage

// File: rtl/schedw_if.sv
// Bundle of run-control inputs and phase/status outputs between top level and sequencer.
// Latency: n/a (wires only).
// Backpressure: mbus_ready is the only stall input; it is honoured in wait states only.
interface schedw_if #(
  parameter int CNT_W = 32
);
  logic             mbus_ready;
  logic             halt_req;
  logic             step_req;
  logic             phf;
  logic             phe;
  logic             phm;
  logic             phw;
  logic [1:0]       bus_phase;
  logic             halted;
  logic [2:0]       clk_stat;
  logic [CNT_W-1:0] insn_cnt;

  // sequencer side
  modport master (
    input  mbus_ready, halt_req, step_req,
    output phf, phe, phm, phw, bus_phase, halted, clk_stat, insn_cnt
  );

  // top-level / core side
  modport slave (
    output mbus_ready, halt_req, step_req,
    input  phf, phe, phm, phw, bus_phase, halted, clk_stat, insn_cnt
  );
endinterface

// File: rtl/schedw_wait.sv
// Loadable down-counter for memory wait states; zero flag says the minimum wait has elapsed.
// Latency: load/decrement visible one cycle later; zero is a combinational decode of the count.
// Backpressure: none; counting saturates at zero and load wins over decrement.
module schedw_wait
  import schedw_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WCNT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [WCNT_W-1:0] cnt_q;
  logic [WCNT_W-1:0] cnt_d;

  // next count: load on wait-state entry, otherwise count down toward zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/schedw.sv
// Four-phase CPU sequencer (F/E/M/W) with memory wait states, halt/single-step and retired count.
// Latency: 6 cycles per instruction minimum (each wait state lasts at least one cycle).
// Backpressure: mbus_ready low holds WF/WM; halt_req only takes effect at the W boundary.
module schedw
  import schedw_pkg::*;
#(
  parameter logic [WCNT_W-1:0] WS_F         = '0,
  parameter logic [WCNT_W-1:0] WS_M         = '0,
  parameter bit                START_HALTED = 1'b0,
  parameter int                CNT_W        = 32
) (
  input  logic     clk,
  input  logic     reset,
  schedw_if.master bus
);

  logic [2:0]       state_q, state_d;
  logic             step_q, step_d;
  logic             resume_q, resume_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              wait_load;
  logic [WCNT_W-1:0] wait_val;
  logic              wait_dec;
  logic              wait_zero;

  schedw_wait u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (wait_load),
    .load_val (wait_val),
    .dec      (wait_dec),
    .zero     (wait_zero)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= START_HALTED ? S_HALT : S_WF;
    end else begin
      state_q <= state_d;
    end
  end

  // next state plus the run-control latches that steer the HALT/W decisions
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    resume_d = resume_q;
    case (state_q)
      S_HALT: begin
        if (bus.step_req) begin
          state_d = S_WF;
          step_d  = 1'b1;
        end else if (!bus.halt_req && (!START_HALTED || resume_q)) begin
          state_d = S_WF;
        end
        // latch only remembers a halt seen while parked; leaving HALT forgets it
        if (state_d == S_WF) begin
          resume_d = 1'b0;
        end else if (bus.halt_req) begin
          resume_d = 1'b1;
        end
      end
      S_WF: if (wait_zero && bus.mbus_ready) state_d = S_F;
      S_F:  state_d = S_E;
      S_E:  state_d = S_WM;
      S_WM: if (wait_zero && bus.mbus_ready) state_d = S_M;
      S_M:  state_d = S_W;
      S_W: begin
        if (bus.halt_req || step_q) begin
          state_d = S_HALT;
          step_d  = 1'b0;
        end else begin
          state_d = S_WF;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  // wait counter control: load on entry to a wait state, count down while inside one
  always_comb begin
    wait_load = ((state_d == S_WF) && (state_q != S_WF)) ||
                ((state_d == S_WM) && (state_q != S_WM));
    wait_val  = (state_d == S_WM) ? WS_M : WS_F;
    wait_dec  = (state_q == S_WF) || (state_q == S_WM);
  end

  // retired-instruction count advances during every W cycle, wrapping silently
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_W) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // run-control latches and instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q   <= 1'b0;
      resume_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      step_q   <= step_d;
      resume_q <= resume_d;
      cnt_q    <= cnt_d;
    end
  end

  // outputs are pure decodes of the current state
  always_comb begin
    bus.phf       = (state_q == S_F);
    bus.phe       = (state_q == S_E);
    bus.phm       = (state_q == S_M);
    bus.phw       = (state_q == S_W);
    bus.halted    = (state_q == S_HALT);
    bus.clk_stat  = state_q;
    bus.insn_cnt  = cnt_q;
    bus.bus_phase = BP_F;
    case (state_q)
      S_E:       bus.bus_phase = BP_E;
      S_WM, S_M: bus.bus_phase = BP_M;
      S_W:       bus.bus_phase = BP_W;
      default:   bus.bus_phase = BP_F;
    endcase
  end

endmodule
